// File: rtl/parity_pkg.sv
// Shared defaults and state encoding for the parity-stage word packer.
// The optional word-count port is enabled with PACKER_WORD_CNT_EN.
package parity_pkg;

  localparam int DATA_WIDTH_DEF = 512;
  localparam int WORD_WIDTH_DEF = 64;
  localparam int WORDS_DEF      = DATA_WIDTH_DEF / WORD_WIDTH_DEF;
  localparam int CNT_W_DEF      = $clog2(WORDS_DEF);

  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } packer_state_e;

endpackage

// File: rtl/parity_word_packer.sv
// Packs WORD_WIDTH-bit words into DATA_WIDTH-bit blocks for the parity stage,
// double-buffered (fill + output register). Optional out_words via PACKER_WORD_CNT_EN.
module parity_word_packer
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_enable,
  output logic [DATA_WIDTH-1:0] out_data,
`ifdef PACKER_WORD_CNT_EN
  output logic [$clog2(DATA_WIDTH/WORD_WIDTH):0] out_words,
`endif
  input  logic                  out_ready
);

  localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

  packer_state_e         state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] fill_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_enable_r;
  logic                  in_ready_r;

  logic                  accept_s;
  logic                  drain_s;
  logic                  complete_s;
  logic                  load_out_s;
  logic [DATA_WIDTH-1:0] merged_s;

  assign in_ready   = in_ready_r;
  assign out_enable = out_enable_r;
  assign out_data   = out_data_r;

  // Handshake decode and the block-load decision shared by the FSM and the word counter.
  always_comb begin
    accept_s   = in_valid && in_ready_r;
    drain_s    = out_enable_r && out_ready;
    complete_s = accept_s && (in_last || (cnt_r == LAST_IDX));
    load_out_s = 1'b0;
    case (state_r)
      FILL:    load_out_s = complete_s && (!out_enable_r || drain_s);
      STALL:   load_out_s = out_ready;
      default: load_out_s = 1'b0;
    endcase
  end

  // Lane write: the incoming word replaces lane cnt_r of the fill register.
  always_comb begin
    merged_s = fill_r;
    for (int i = 0; i < WORDS; i++) begin
      if (cnt_r == CNT_W'(i)) begin
        merged_s[i*WORD_WIDTH +: WORD_WIDTH] = in_data;
      end else begin
        merged_s[i*WORD_WIDTH +: WORD_WIDTH] = fill_r[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Fill/stall state machine with registered handshake and block outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FILL;
      cnt_r        <= '0;
      fill_r       <= '0;
      out_data_r   <= '0;
      out_enable_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      case (state_r)
        FILL: begin
          if (complete_s && load_out_s) begin
            out_data_r   <= merged_s;
            out_enable_r <= 1'b1;
            fill_r       <= '0;
            cnt_r        <= '0;
            in_ready_r   <= 1'b1;
          end else if (complete_s) begin
            // Output still occupied: park the finished block; cnt_r keeps its last lane.
            fill_r     <= merged_s;
            state_r    <= STALL;
            in_ready_r <= 1'b0;
          end else if (accept_s) begin
            fill_r     <= merged_s;
            cnt_r      <= cnt_r + CNT_W'(1);
            in_ready_r <= 1'b1;
            if (drain_s) begin
              out_enable_r <= 1'b0;
            end
          end else begin
            in_ready_r <= 1'b1;
            if (drain_s) begin
              out_enable_r <= 1'b0;
            end
          end
        end
        STALL: begin
          if (load_out_s) begin
            out_data_r   <= fill_r;
            out_enable_r <= 1'b1;
            fill_r       <= '0;
            cnt_r        <= '0;
            state_r      <= FILL;
            in_ready_r   <= 1'b1;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= FILL;
          in_ready_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACKER_WORD_CNT_EN
  logic [CNT_W:0] out_words_r;
  logic [CNT_W:0] words_s;

  // The block being loaded always ends at lane cnt_r, so its size is cnt_r + 1.
  assign words_s   = {1'b0, cnt_r} + (CNT_W + 1)'(1);
  assign out_words = out_words_r;

  // Word count travels with out_data and is held while the block waits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_words_r <= '0;
    end else if (load_out_s) begin
      out_words_r <= words_s;
    end else begin
      out_words_r <= out_words_r;
    end
  end
`endif

endmodule
